ls_exec_unit: RTL

Load/store execute unit that sits at the consuming end of the load/store reservation station's 100-bit issue packet. It buffers issued packets, reads source values from the physical register file, and computes the effective address. It then performs the memory access over a valid/ready request and valid response interface, and broadcasts the load destination tag (`EX_MEM_MemRead`, `EX_MEM_Physical_Address`) back to the reservation stations for operand wakeup.

---
 rtl/ls_pkg.sv | 51 +++++
 rtl/ls_issue_fifo.sv | 57 +++++
 rtl/ls_exec_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ls_pkg.sv
// Shared definitions for the load/store execute unit:
// packet layout, funct3 encodings, FSM states.
package ls_pkg;

    localparam int PKT_W        = 100;

    localparam int IMM_LSB      = 0;
    localparam int F3_LSB       = 32;
    localparam int ALUSRC2_BIT  = 35;
    localparam int ALUOP_LSB    = 36;
    localparam int MEMWRITE_BIT = 40;
    localparam int MEMREAD_BIT  = 41;
    localparam int MEMTOREG_BIT = 42;
    localparam int RD_LSB       = 43;
    localparam int VALID_BIT    = 51;
    localparam int INST_LSB     = 52;
    localparam int OP1_LSB      = 84;
    localparam int OP2_LSB      = 92;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_ADDR,
        ST_REQ,
        ST_WAIT,
        ST_WB
    } ls_state_e;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] a);
        logic m;
        m = 1'b0;
        case (f3[1:0])
            F3_LH[1:0]: m = a[0];
            F3_SW[1:0]: m = |a;
            default:    m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ls_issue_fifo.sv
// Circular issue-packet buffer with wrap-around pointers
// and an occupancy count.
module ls_issue_fifo
    import ls_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [PKT_W-1:0] wdata_i,
    input  logic             pop_i,
    output logic [PKT_W-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [PKT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign rdata_o = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Packet storage; a pop frees its slot in the same cycle.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy, cleared on flush.
    always_ff @(posedge clk) begin
        if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ls_exec_unit.sv
// Load/store execute unit: buffers issued packets, reads
// the PRF, computes the address and runs one memory op.
module ls_exec_unit
    import ls_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exception_sig,
    input  logic             mret_sig,
    input  logic [PKT_W-1:0] issue_pkt,
    output logic [7:0]       prf_rs1_tag,
    output logic [7:0]       prf_rs2_tag,
    input  logic [31:0]      prf_rs1_data,
    input  logic [31:0]      prf_rs2_data,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_req_we,
    output logic [31:0]      mem_req_addr,
    output logic [31:0]      mem_req_wdata,
    output logic [3:0]       mem_req_be,
    input  logic             mem_rsp_valid,
    input  logic [31:0]      mem_rsp_rdata,
    output logic             EX_MEM_MemRead,
    output logic [7:0]       EX_MEM_Physical_Address,
    output logic             wb_valid,
    output logic [7:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic [31:0]      wb_inst_num,
    output logic             misalign_exc,
    output logic [31:0]      misalign_inst_num,
    output logic             overflow_err
);

    ls_state_e        state_q, state_d;
    logic [PKT_W-1:0] pkt_q, fifo_rdata;
    logic [31:0]      addr_q, rs2_q, wb_data_q;
    logic [31:0]      addr_calc, rsp_shift, load_fmt;
    logic             drop_rsp_q, drop_rsp_d;
    logic             ovf_q, ovf_d;
    logic             exc_flush, flush, push, pop;
    logic             fifo_full, fifo_empty;
    logic [3:0]       be;
    logic             unused_fields;

    wire [2:0]  f3       = pkt_q[F3_LSB +: 3];
    wire [31:0] imm      = pkt_q[IMM_LSB +: 32];
    wire [7:0]  rd       = pkt_q[RD_LSB +: 8];
    wire [31:0] inum     = pkt_q[INST_LSB +: 32];
    wire        is_store = pkt_q[MEMWRITE_BIT];

    assign unused_fields = ^{pkt_q[ALUSRC2_BIT], pkt_q[ALUOP_LSB +: 4],
                             pkt_q[MEMREAD_BIT], pkt_q[MEMTOREG_BIT],
                             pkt_q[VALID_BIT]};

    assign exc_flush = exception_sig | mret_sig;
    assign flush     = reset | exc_flush;
    assign push      = issue_pkt[VALID_BIT] && !flush;
    assign addr_calc = prf_rs1_data + imm;

    ls_issue_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (issue_pkt),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next state and per-state pulses; a flush overrides all.
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        misalign_exc  = 1'b0;
        mem_req_valid = 1'b0;
        wb_valid      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_RD;
                end
            end
            ST_RD:   state_d = ST_ADDR;
            ST_ADDR: begin
                if (misaligned(f3, addr_calc[1:0])) begin
                    misalign_exc = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = is_store ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid && !drop_rsp_q) state_d = ST_WB;
            end
            ST_WB: begin
                wb_valid = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d       = ST_IDLE;
            pop           = 1'b0;
            misalign_exc  = 1'b0;
            mem_req_valid = 1'b0;
            wb_valid      = 1'b0;
        end
    end

    // Stale-response tracking and sticky overflow flag.
    always_comb begin
        drop_rsp_d = drop_rsp_q;
        if (mem_rsp_valid && drop_rsp_q) drop_rsp_d = 1'b0;
        if (exc_flush && state_q == ST_WAIT &&
            !(mem_rsp_valid && !drop_rsp_q)) begin
            drop_rsp_d = 1'b1;
        end
        ovf_d = ovf_q | (issue_pkt[VALID_BIT] && fifo_full && !pop);
        if (exc_flush) ovf_d = 1'b0;
    end

    // Byte enables from access size and byte offset.
    always_comb begin
        case (f3[1:0])
            F3_SB[1:0]: be = 4'b0001 << addr_q[1:0];
            F3_SH[1:0]: be = 4'b0011 << addr_q[1:0];
            default:    be = 4'b1111;
        endcase
    end

    // Align the response to bit 0, then extend per funct3.
    always_comb begin
        rsp_shift = mem_rsp_rdata >> {addr_q[1:0], 3'b000};
        case (f3)
            F3_LB:   load_fmt = {{24{rsp_shift[7]}}, rsp_shift[7:0]};
            F3_LH:   load_fmt = {{16{rsp_shift[15]}}, rsp_shift[15:0]};
            F3_LW:   load_fmt = rsp_shift;
            F3_LBU:  load_fmt = {24'b0, rsp_shift[7:0]};
            F3_LHU:  load_fmt = {16'b0, rsp_shift[15:0]};
            default: load_fmt = rsp_shift;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            drop_rsp_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            drop_rsp_q <= drop_rsp_d;
            ovf_q      <= ovf_d;
        end
    end

    // Working packet, captured address/store data, load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q     <= '0;
            addr_q    <= '0;
            rs2_q     <= '0;
            wb_data_q <= '0;
        end else begin
            if (pop) pkt_q <= fifo_rdata;
            if (state_q == ST_ADDR) begin
                addr_q <= addr_calc;
                rs2_q  <= prf_rs2_data;
            end
            if (state_q == ST_WAIT && mem_rsp_valid && !drop_rsp_q) begin
                wb_data_q <= load_fmt;
            end
        end
    end

    assign prf_rs1_tag = (state_q == ST_RD) ? pkt_q[OP1_LSB +: 8] : '0;
    assign prf_rs2_tag = (state_q == ST_RD) ? pkt_q[OP2_LSB +: 8] : '0;

    assign mem_req_we    = mem_req_valid & is_store;
    assign mem_req_addr  = mem_req_valid ? {addr_q[31:2], 2'b00} : '0;
    assign mem_req_wdata = mem_req_valid ?
                           (rs2_q << {addr_q[1:0], 3'b000}) : '0;
    assign mem_req_be    = mem_req_valid ? be : '0;

    assign EX_MEM_MemRead          = wb_valid;
    assign EX_MEM_Physical_Address = wb_valid ? rd : '0;
    assign wb_rd                   = wb_valid ? rd : '0;
    assign wb_data                 = wb_valid ? wb_data_q : '0;
    assign wb_inst_num             = wb_valid ? inum : '0;

    assign misalign_inst_num = misalign_exc ? inum : '0;
    assign overflow_err      = ovf_q;

endmodule
